hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 16-bit 5-stage core. It drives the write-enable (wen) and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB state registers. It consumes the ID/EX register's outputs (regwrite, memtoreg, reg_write_select) together with the decode-stage source selects. It resolves load-use hazards, taken-branch squashes, multi-cycle data-memory waits and HLT.

Parameters:
MEM_TIMEOUT, 64, number of consecutive mem_busy cycles after which mem_timeout is flagged; range 2..255.
WAIT_W, 8, width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  asynchronous active-high reset.
sel_reg_1_id  input  4  decode-stage source register 1.
sel_reg_2_id  input  4  decode-stage source register 2.
uses_reg_1_id  input  1  decode instruction reads source 1.
uses_reg_2_id  input  1  decode instruction reads source 2.
regwrite_current  input  1  from ID/EX.
memtoreg_current  input  1  from ID/EX; high = load in EX.
reg_write_select_current  input  4  from ID/EX; destination register.
branch_taken_ex  input  1  taken branch or jump resolved in EX.
mem_busy  input  1  data memory not ready this cycle.
halt_wb  input  1  HLT instruction in MEM/WB.
pc_wen  output  1  PC write enable.
if_id_wen  output  1  IF/ID write enable.
if_id_flush  output  1  load NOP into IF/ID.
id_ex_wen  output  1  ID/EX write enable.
id_ex_flush  output  1  load bubble (all controls 0) into ID/EX.
ex_mem_wen  output  1  EX/MEM write enable.
mem_wb_wen  output  1  MEM/WB write enable.
halted  output  1  core halted (registered).
mem_timeout  output  1  sticky error flag (registered).

Behaviour:
- States: RUN, MEM_WAIT, HALT. State is 2-bit and encoded. Outputs are a combinational function of state and inputs.
- Reset:
  - State goes to RUN; wait_cnt, halted and mem_timeout go to 0.
  - While rst is high, all wen and flush outputs are 0.
- Priority, highest first: HALT state, halt_wb, mem_busy, branch_taken_ex, load-use. Only the highest active condition acts.
- HALT state:
  - All wen = 0, all flush = 0, halted = 1.
  - Leaves HALT only on rst.
- halt_wb = 1 in RUN or MEM_WAIT:
  - All wen = 0 that cycle.
  - Next state is HALT; halted rises on the next edge.
- mem_busy = 1:
  - All five wen = 0, flush = 0 (full freeze).
  - Next state is MEM_WAIT.
  - wait_cnt increments and saturates at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set and stays set until rst.
- MEM_WAIT with mem_busy = 0:
  - Outputs follow RUN rules in that same cycle (zero-cycle release).
  - Next state is RUN; wait_cnt clears.
- Branch taken, not frozen:
  - All wen = 1, if_id_flush = 1, id_ex_flush = 1.
  - The two younger instructions are squashed; PC loads the target.
- Load-use: asserted when all of the following hold:
  - memtoreg_current and regwrite_current are both 1;
  - reg_write_select_current != 0;
  - either (uses_reg_1_id and sel_reg_1_id == reg_write_select_current) or (uses_reg_2_id and sel_reg_2_id == reg_write_select_current).
- Load-use response:
  - pc_wen = 0, if_id_wen = 0, id_ex_flush = 1, id_ex_wen = 1, ex_mem_wen = 1, mem_wb_wen = 1.
  - Exactly one bubble is inserted. The next cycle the bubble sits in ID/EX (memtoreg = 0), so the hazard self-clears.
- R0 is hardwired zero and never causes a stall.
- Branch and load-use together: branch wins, because the stalled instruction is squashed.
- A flush implies wen = 1 on the same register. The flush takes effect only when the matching wen is 1.
- Default (no hazard): all wen = 1, flushes = 0.

Optional Feature:
STALL_CNT_EN:
- Defined: adds output stall_cnt[15:0] and output bubble_cnt[15:0], both reset to 0 and wrapping from 0xFFFF to 0.
  - stall_cnt increments on every cycle with pc_wen = 0 while not in HALT and not in reset.
  - bubble_cnt increments on every load-use bubble and every branch flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Load R3 in EX (memtoreg = 1, regwrite = 1, dst = 3), decode reads sel_reg_1_id = 3 with uses = 1 -> one cycle of pc_wen = 0, if_id_wen = 0, id_ex_flush = 1; next cycle all wen = 1.
2. Same as test 1 but dst = 0, or uses_reg_1_id = 0 -> no stall; all wen = 1.
3. mem_busy held high for 5 cycles -> all wen = 0 for exactly 5 cycles; release in the 6th cycle. With MEM_TIMEOUT = 4, mem_timeout = 1 and stays 1.
4. branch_taken_ex = 1 together with a load-use match -> if_id_flush = 1, id_ex_flush = 1, pc_wen = 1, no stall. With mem_busy = 1 added -> freeze only, no flush.
5. halt_wb = 1 -> all wen = 0 immediately; halted = 1 after the edge; remains frozen for 20 cycles with random inputs; async rst mid-cycle -> outputs 0 at once; after release, state RUN and halted = 0.
6. With STALL_CNT_EN defined: 3 load-use stalls, 2 branches and 4 mem_busy cycles -> stall_cnt = 7, bubble_cnt = 5.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the pipeline registers and hazard_ctrl.
// Optional stall/bubble counters appear when STALL_CNT_EN is defined.
interface hazard_ctrl_if;
    logic [3:0]  sel_reg_1_id;
    logic [3:0]  sel_reg_2_id;
    logic        uses_reg_1_id;
    logic        uses_reg_2_id;
    logic        regwrite_current;
    logic        memtoreg_current;
    logic [3:0]  reg_write_select_current;
    logic        branch_taken_ex;
    logic        mem_busy;
    logic        halt_wb;
    logic        pc_wen;
    logic        if_id_wen;
    logic        if_id_flush;
    logic        id_ex_wen;
    logic        id_ex_flush;
    logic        ex_mem_wen;
    logic        mem_wb_wen;
    logic        halted;
    logic        mem_timeout;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;
`endif

    modport master (
        output sel_reg_1_id,
        output sel_reg_2_id,
        output uses_reg_1_id,
        output uses_reg_2_id,
        output regwrite_current,
        output memtoreg_current,
        output reg_write_select_current,
        output branch_taken_ex,
        output mem_busy,
        output halt_wb,
        input  pc_wen,
        input  if_id_wen,
        input  if_id_flush,
        input  id_ex_wen,
        input  id_ex_flush,
        input  ex_mem_wen,
        input  mem_wb_wen,
        input  halted,
        input  mem_timeout
`ifdef STALL_CNT_EN
        ,
        input  stall_cnt,
        input  bubble_cnt
`endif
    );

    modport slave (
        input  sel_reg_1_id,
        input  sel_reg_2_id,
        input  uses_reg_1_id,
        input  uses_reg_2_id,
        input  regwrite_current,
        input  memtoreg_current,
        input  reg_write_select_current,
        input  branch_taken_ex,
        input  mem_busy,
        input  halt_wb,
        output pc_wen,
        output if_id_wen,
        output if_id_flush,
        output id_ex_wen,
        output id_ex_flush,
        output ex_mem_wen,
        output mem_wb_wen,
        output halted,
        output mem_timeout
`ifdef STALL_CNT_EN
        ,
        output stall_cnt,
        output bubble_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use, branch, mem wait, HLT.
// Define STALL_CNT_EN to add the stall_cnt / bubble_cnt performance counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              halted_q;
    logic              timeout_q;

    logic dst_nz;
    logic is_load;
    logic hit_1;
    logic hit_2;
    logic load_use;

    assign dst_nz  = hz.reg_write_select_current != 4'd0;
    assign is_load = hz.memtoreg_current && hz.regwrite_current;
    assign hit_1   = hz.uses_reg_1_id &&
                     (hz.sel_reg_1_id == hz.reg_write_select_current);
    assign hit_2   = hz.uses_reg_2_id &&
                     (hz.sel_reg_2_id == hz.reg_write_select_current);
    assign load_use = is_load && dst_nz && (hit_1 || hit_2);

    // One-hot action decode; only the highest-priority condition is live.
    logic live;
    logic do_halt;
    logic do_freeze;
    logic do_branch;
    logic do_stall;
    logic freeze_all;

    assign live      = !rst && (state != HALT);
    assign do_halt   = live && hz.halt_wb;
    assign do_freeze = live && !hz.halt_wb && hz.mem_busy;
    assign do_branch = live && !hz.halt_wb && !hz.mem_busy &&
                       hz.branch_taken_ex;
    assign do_stall  = live && !hz.halt_wb && !hz.mem_busy &&
                       !hz.branch_taken_ex && load_use;
    assign freeze_all = !live || do_halt || do_freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        hz.pc_wen      = 1'b1;
        hz.if_id_wen   = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_wen   = 1'b1;
        hz.id_ex_flush = 1'b0;
        hz.ex_mem_wen  = 1'b1;
        hz.mem_wb_wen  = 1'b1;
        unique case (1'b1)
            !live: begin
                state_nxt = state;
            end
            do_halt: begin
                state_nxt = HALT;
            end
            do_freeze: begin
                state_nxt = MEM_WAIT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (freeze_all) begin
            hz.pc_wen     = 1'b0;
            hz.if_id_wen  = 1'b0;
            hz.id_ex_wen  = 1'b0;
            hz.ex_mem_wen = 1'b0;
            hz.mem_wb_wen = 1'b0;
        end
        if (do_stall) begin
            hz.pc_wen      = 1'b0;
            hz.if_id_wen   = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
        if (do_branch) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end
    end

    // Consecutive-busy counter saturates so the sticky flag cannot wrap away.
    always_comb begin
        wait_nxt = '0;
        if (do_freeze) begin
            if (wait_cnt == TMO) begin
                wait_nxt = wait_cnt;
            end else begin
                wait_nxt = wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            halted_q <= state_nxt == HALT;
            if (wait_nxt == TMO) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign hz.halted      = halted_q;
    assign hz.mem_timeout = timeout_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (state != HALT && !hz.pc_wen) begin
                stall_q <= stall_q + 16'd1;
            end
            if (do_branch || do_stall) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end
    end

    assign hz.stall_cnt  = stall_q;
    assign hz.bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: random and directed stimulus vs a rule model.
// Counter checks are active when STALL_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b1;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MEM_TIMEOUT(TMO),
        .WAIT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hif)
    );

    typedef struct {
        logic [6:0]  w;
        logic        hlt;
        logic        tmo;
        logic [15:0] sc;
        logic [15:0] bc;
    } exp_t;

    exp_t q[$];

    int compared   = 0;
    int mismatched = 0;

    bit          m_halt;
    int          m_busy;
    bit          m_tmo;
    logic [15:0] m_sc;
    logic [15:0] m_bc;
    int          busy_left = 0;

    task automatic model_reset();
        m_halt = 0;
        m_busy = 0;
        m_tmo  = 0;
        m_sc   = '0;
        m_bc   = '0;
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs, advance model.
    task automatic apply(input logic [3:0] s1, input logic [3:0] s2,
                         input logic u1, input logic u2,
                         input logic rw, input logic mr,
                         input logic [3:0] dst, input logic br,
                         input logic mb, input logic hw);
        exp_t e;
        logic lu;
        hif.sel_reg_1_id             = s1;
        hif.sel_reg_2_id             = s2;
        hif.uses_reg_1_id            = u1;
        hif.uses_reg_2_id            = u2;
        hif.regwrite_current         = rw;
        hif.memtoreg_current         = mr;
        hif.reg_write_select_current = dst;
        hif.branch_taken_ex          = br;
        hif.mem_busy                 = mb;
        hif.halt_wb                  = hw;
        if (rst) model_reset();
        lu = mr && rw && (dst != 0) &&
             ((u1 && s1 == dst) || (u2 && s2 == dst));
        if (rst || m_halt || hw || mb) e.w = 7'b0000000;
        else if (br)                   e.w = 7'b1111111;
        else if (lu)                   e.w = 7'b0001111;
        else                           e.w = 7'b1101011;
        e.hlt = m_halt;
        e.tmo = m_tmo;
        e.sc  = m_sc;
        e.bc  = m_bc;
        q.push_back(e);
        if (!rst && !m_halt) begin
            if (!e.w[6]) m_sc = m_sc + 16'd1;
            if (!hw && !mb && (br || lu)) m_bc = m_bc + 16'd1;
            if (hw) begin
                m_halt = 1;
                m_busy = 0;
            end else if (mb) begin
                if (m_busy < TMO) m_busy++;
                if (m_busy >= TMO) m_tmo = 1;
            end else begin
                m_busy = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] s1, input logic [3:0] s2,
                        input logic u1, input logic u2,
                        input logic rw, input logic mr,
                        input logic [3:0] dst, input logic br,
                        input logic mb, input logic hw);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(s1, s2, u1, u2, rw, mr, dst, br, mb, hw);
    endtask

    task automatic idle();
        step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rnd_step(input int halt_odds);
        logic mb;
        logic hw;
        if (busy_left > 0) begin
            mb = 1'b1;
            busy_left--;
        end else if ($urandom_range(0, 9) == 0) begin
            mb = 1'b1;
            busy_left = $urandom_range(0, 5);
        end else begin
            mb = 1'b0;
        end
        hw = (halt_odds > 0) && ($urandom_range(0, halt_odds - 1) == 0);
        step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
             mb, hw);
    endtask

    // Reset asserted mid-cycle; outputs must drop in that same cycle.
    task automatic async_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        busy_left = 0;
        apply(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              1'b1, 1'b1, 1'b1, 1'b1, 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    endtask

    initial begin : monitor
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {hif.pc_wen, hif.if_id_wen, hif.if_id_flush,
                       hif.id_ex_wen, hif.id_ex_flush,
                       hif.ex_mem_wen, hif.mem_wb_wen};
                compared++;
                if (act !== e.w) begin
                    mismatched++;
                    $display("FAIL wen_flush t=%0t act=%b exp=%b",
                             $time, act, e.w);
                end
                compared++;
                if (hif.halted !== e.hlt) begin
                    mismatched++;
                    $display("FAIL halted t=%0t act=%b exp=%b",
                             $time, hif.halted, e.hlt);
                end
                compared++;
                if (hif.mem_timeout !== e.tmo) begin
                    mismatched++;
                    $display("FAIL mem_timeout t=%0t act=%b exp=%b",
                             $time, hif.mem_timeout, e.tmo);
                end
`ifdef STALL_CNT_EN
                compared++;
                if (hif.stall_cnt !== e.sc) begin
                    mismatched++;
                    $display("FAIL stall_cnt t=%0t act=%0d exp=%0d",
                             $time, hif.stall_cnt, e.sc);
                end
                compared++;
                if (hif.bubble_cnt !== e.bc) begin
                    mismatched++;
                    $display("FAIL bubble_cnt t=%0t act=%0d exp=%0d",
                             $time, hif.bubble_cnt, e.bc);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst = 1'b1;
        model_reset();
        #1;
        apply(4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        apply(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // load-use on src1, then bubble in ID/EX
        step(4'd3, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        // R0 destination, unused source, src2 match, non-load
        step(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(4'd3, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        // five busy cycles, release in the sixth
        for (int i = 0; i < 5; i++)
            step(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        idle();
        idle();
        // branch beats load-use; busy beats branch
        step(4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        step(4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        idle();
        async_reset();
        idle();

        // three load-use stalls, two branches, four busy cycles
        for (int i = 0; i < 3; i++) begin
            step(4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
            idle();
        end
        for (int i = 0; i < 2; i++) begin
            step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
            idle();
        end
        for (int i = 0; i < 4; i++)
            step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();

        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 299) async_reset();
            else rnd_step(0);
        end

        // HLT, then 20 random frozen cycles, then mid-cycle reset
        async_reset();
        idle();
        step(4'd1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) rnd_step(3);
        async_reset();
        idle();
        idle();

        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 149) async_reset();
            else rnd_step(60);
        end

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
